time_tmr_link: RTL and testbench

Time-redundant (temporal TMR) transport for a valid/ready stream. A start stage accepts each upstream item, tags it with a rolling ID and emits it three times on a redundant channel. An end stage collects the copies, majority-votes on {ID, data} and forwards exactly one corrected item downstream. The redundant channel is exposed as ports so it can run through a fault-prone path.

---
 rtl/time_tmr_link.sv | 191 +++++++++++++++++++
 tb/tb_time_tmr_link.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_tmr_link.sv
// Temporal-TMR link: the start stage replays each tagged item three times over a
// redundant channel, and the end stage majority-votes the copies back into one item.
module time_tmr_link #(
  parameter int DataWidth   = 8,
  parameter int IDSize      = 4,
  parameter int LockTimeout = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [DataWidth-1:0] red_data_o,
  output logic [IDSize-1:0]    red_id_o,
  output logic                 red_valid_o,
  input  logic                 red_ready_i,
  input  logic [DataWidth-1:0] red_data_i,
  input  logic [IDSize-1:0]    red_id_i,
  input  logic                 red_valid_i,
  output logic                 red_ready_o,
  output logic [DataWidth-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 lock_o,
  output logic                 fault_detected_o
);

  localparam int IdleW = (LockTimeout < 2) ? 1 : $clog2(LockTimeout + 1);

  typedef struct packed {
    logic                 occ;
    logic [IDSize-1:0]    id;
    logic [DataWidth-1:0] data;
  } entry_t;

  logic [1:0]           count;
  logic [DataWidth-1:0] buf_data;
  logic [IDSize-1:0]    buf_id;
  logic [IDSize-1:0]    next_id;
  logic                 up_hs;
  logic                 red_out_hs;

  always_comb begin
    ready_o     = 1'b0;
    red_valid_o = 1'b0;
    red_data_o  = buf_data;
    red_id_o    = buf_id;
    if (enable_i) begin
      ready_o     = !rst_i && ((count == 2'd0) || (count == 2'd1 && red_ready_i));
      red_valid_o = !rst_i && (count != 2'd0);
    end else begin
      ready_o     = !rst_i && red_ready_i;
      red_valid_o = !rst_i && valid_i;
      red_data_o  = data_i;
      red_id_o    = next_id;
    end
    up_hs      = valid_i && ready_o;
    red_out_hs = red_valid_o && red_ready_i;
  end

  // A fresh upstream item takes precedence over retiring the last copy of the old one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count    <= 2'd0;
      buf_data <= '0;
      buf_id   <= '0;
      next_id  <= '0;
    end else if (enable_i) begin
      if (up_hs) begin
        count    <= 2'd3;
        buf_data <= data_i;
        buf_id   <= next_id;
        next_id  <= next_id + IDSize'(1);
      end else if (red_out_hs) begin
        count <= count - 2'd1;
      end
    end else if (up_hs) begin
      next_id <= next_id + IDSize'(1);
    end
  end

  entry_t [2:0]         win, win_n;
  logic                 lock, lock_n;
  logic [IDSize-1:0]    lock_id, lock_id_n;
  logic [DataWidth-1:0] voted, voted_n;
  logic [DataWidth-1:0] out_data, out_data_n;
  logic                 out_valid, out_valid_n;
  logic [IdleW-1:0]     idle_cnt, idle_n;
  logic                 fault_q, fault_n;
  logic                 red_in_hs;
  logic                 match;
  entry_t               pick;
  entry_t               new_entry;

  function automatic logic same(input entry_t a, input entry_t b);
    return a.occ && b.occ && (a.id == b.id) && (a.data == b.data);
  endfunction

  // Copies carrying the locked ID are stragglers of an item already voted out.
  always_comb begin
    win_n       = win;
    lock_n      = lock;
    lock_id_n   = lock_id;
    voted_n     = voted;
    out_data_n  = out_data;
    out_valid_n = out_valid;
    idle_n      = idle_cnt;
    fault_n     = 1'b0;
    match       = 1'b0;
    pick        = '0;
    new_entry   = entry_t'({1'b1, red_id_i, red_data_i});
    red_in_hs   = red_valid_i && red_ready_o;

    if (out_valid && ready_i) begin
      out_valid_n = 1'b0;
    end

    if (red_in_hs) begin
      idle_n = '0;
      if (lock && red_id_i == lock_id) begin
        fault_n = (red_data_i != voted);
      end else begin
        lock_n = 1'b0;
        win_n  = {win[1], win[0], new_entry};
        if (same(win_n[0], win_n[1]) || same(win_n[0], win_n[2])) begin
          match = 1'b1;
          pick  = win_n[0];
        end else if (same(win_n[1], win_n[2])) begin
          match = 1'b1;
          pick  = win_n[1];
        end
        if (match) begin
          out_data_n  = pick.data;
          out_valid_n = 1'b1;
          win_n       = '0;
          lock_n      = 1'b1;
          lock_id_n   = pick.id;
          voted_n     = pick.data;
        end else if (win_n[0].occ && win_n[1].occ && win_n[2].occ) begin
          fault_n = 1'b1;
        end
      end
    end else if (idle_cnt == IdleW'(LockTimeout - 1)) begin
      lock_n = 1'b0;
      win_n  = '0;
      idle_n = '0;
    end else begin
      idle_n = idle_cnt + IdleW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      win       <= '0;
      lock      <= 1'b0;
      lock_id   <= '0;
      voted     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      idle_cnt  <= '0;
      fault_q   <= 1'b0;
    end else if (enable_i) begin
      win       <= win_n;
      lock      <= lock_n;
      lock_id   <= lock_id_n;
      voted     <= voted_n;
      out_data  <= out_data_n;
      out_valid <= out_valid_n;
      idle_cnt  <= idle_n;
      fault_q   <= fault_n;
    end else begin
      fault_q <= 1'b0;
    end
  end

  always_comb begin
    if (enable_i) begin
      red_ready_o = !rst_i && (!out_valid || ready_i);
      valid_o     = !rst_i && out_valid;
      data_o      = out_data;
    end else begin
      red_ready_o = !rst_i && ready_i;
      valid_o     = !rst_i && red_valid_i;
      data_o      = red_data_i;
    end
    lock_o           = enable_i && lock;
    fault_detected_o = fault_q;
  end

endmodule

// File: tb/tb_time_tmr_link.sv
// Bench for time_tmr_link: start stage looped to end stage through a fault-injecting
// channel, with an in-order scoreboard of accepted items as the reference.
module tb_time_tmr_link;

  localparam int DW = 8;
  localparam int IW = 4;
  localparam int LT = 4;

  logic          clk = 1'b0;
  logic          rst, enable;
  logic [DW-1:0] up_data;
  logic          up_valid, up_ready;
  logic [DW-1:0] red_data_s, red_data_e;
  logic [IW-1:0] red_id_s, red_id_e;
  logic          red_valid_s, red_valid_e, red_ready_s, red_ready_e;
  logic [DW-1:0] dn_data;
  logic          dn_valid, dn_ready;
  logic          lock, fault;
  logic [DW-1:0] inj_data;
  logic [IW-1:0] inj_id;
  logic          inj_valid, inj_ready;

  always #5 clk = ~clk;

  assign red_data_e  = red_data_s ^ inj_data;
  assign red_id_e    = red_id_s ^ inj_id;
  assign red_valid_e = red_valid_s | inj_valid;
  assign red_ready_s = red_ready_e ^ inj_ready;

  time_tmr_link #(.DataWidth(DW), .IDSize(IW), .LockTimeout(LT)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable),
    .data_i(up_data), .valid_i(up_valid), .ready_o(up_ready),
    .red_data_o(red_data_s), .red_id_o(red_id_s), .red_valid_o(red_valid_s),
    .red_ready_i(red_ready_s),
    .red_data_i(red_data_e), .red_id_i(red_id_e), .red_valid_i(red_valid_e),
    .red_ready_o(red_ready_e),
    .data_o(dn_data), .valid_o(dn_valid), .ready_i(dn_ready),
    .lock_o(lock), .fault_detected_o(fault)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          valid;
    logic          rdy;
    logic [DW-1:0] exp_data;
    logic          exp_valid;
    logic          exp_ready;
    logic [IW-1:0] exp_id;
  } vec_t;

  vec_t          vecs[6];
  logic [DW-1:0] exp_q[$];
  int            checks = 0, errors = 0;
  int            in_count, out_count, fault_count, inj_count, gap;
  bit            mon_en = 1'b0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h required %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted upstream item must emerge exactly once, in order.
  initial begin
    bit            prev_stall;
    logic [DW-1:0] prev_data, exp;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        if (up_valid && up_ready) begin
          exp_q.push_back(up_data);
          in_count++;
        end
        if (enable && prev_stall) begin
          checks++;
          if (!dn_valid || dn_data !== prev_data) begin
            errors++;
            $display("[TB] FAIL stall_hold got valid=%0b data=%02h required valid=1 data=%02h",
                     dn_valid, dn_data, prev_data);
          end
        end
        if (dn_valid && dn_ready) begin
          out_count++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL extra_item got %02h required none", dn_data);
          end else begin
            exp = exp_q.pop_front();
            if (dn_data !== exp) begin
              errors++;
              $display("[TB] FAIL order_data got %02h required %02h", dn_data, exp);
            end
          end
        end
        if (fault) fault_count++;
        prev_stall = dn_valid && !dn_ready;
        prev_data  = dn_data;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic clear_stats();
    exp_q.delete();
    in_count    = 0;
    out_count   = 0;
    fault_count = 0;
    inj_count   = 0;
    gap         = 15;
  endtask

  task automatic do_reset(input logic en);
    mon_en   = 1'b0;
    enable   = en;
    rst      = 1'b1;
    up_valid = 1'b0;
    up_data  = '0;
    dn_ready = 1'b1;
    inj_data = '0;
    inj_id   = '0;
    inj_valid = 1'b0;
    inj_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One cycle per iteration: hold an unaccepted item, stall downstream in a window,
  // and corrupt one live channel transfer every 15-20 cycles according to mode.
  task automatic apply_stimulus(input int n, input int dens, input int mode, input int stall_start);
    logic acc;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      acc = up_valid && up_ready;
      @(posedge clk);
      #1;
      inj_data  = '0;
      inj_id    = '0;
      inj_ready = 1'b0;
      inj_valid = 1'b0;
      dn_ready  = !(stall_start >= 0 && c >= stall_start && c < stall_start + 20);
      if (acc || !up_valid) begin
        up_valid = ($urandom_range(99) < dens);
        up_data  = DW'($urandom);
      end
      #1;
      if (gap > 0) begin
        gap--;
      end else if (mode != 0 && red_valid_s && red_ready_e) begin
        case (mode)
          1: inj_data  = DW'($urandom_range(255, 1));
          2: inj_id    = IW'($urandom_range(15, 1));
          default: inj_ready = 1'b1;
        endcase
        inj_count++;
        gap = $urandom_range(20, 15);
      end
    end
  endtask

  task automatic run_phase(input string name, input int n, input int dens, input int mode,
                           input int stall_start);
    clear_stats();
    mon_en = 1'b1;
    apply_stimulus(n, dens, mode, stall_start);
    apply_stimulus(40, 0, 0, -1);
    mon_en = 1'b0;
    check_output({name, "_count"}, out_count, in_count);
    check_output({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    bit seen;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 4'd0};
    vecs[1] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 4'd1};
    vecs[2] = '{8'h7E, 1'b1, 1'b0, 8'h7E, 1'b1, 1'b0, 4'd1};
    vecs[3] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b1, 1'b1, 4'd1};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 4'd2};
    vecs[5] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd3};

    // Reset state in redundant mode.
    enable = 1'b1;
    rst    = 1'b1;
    up_valid = 1'b0; up_data = '0; dn_ready = 1'b1;
    inj_data = '0; inj_id = '0; inj_valid = 1'b0; inj_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_output("rst_ready_o", up_ready, 1'b0);
    check_output("rst_red_valid", red_valid_s, 1'b0);
    check_output("rst_valid_o", dn_valid, 1'b0);
    check_output("rst_red_ready", red_ready_e, 1'b0);
    #1 rst = 1'b0;
    #1;
    check_output("post_rst_ready_o", up_ready, 1'b1);
    check_output("post_rst_outputs", {dn_data, red_id_s, lock, fault}, '0);

    // Bypass truth table, including next_id advancing only on handshakes.
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) begin
      up_data  = vecs[i].data;
      up_valid = vecs[i].valid;
      dn_ready = vecs[i].rdy;
      #1;
      check_output($sformatf("bypass_vec%0d", i),
                   {dn_data, dn_valid, up_ready, red_id_s, lock, fault},
                   {vecs[i].exp_data, vecs[i].exp_valid, vecs[i].exp_ready, vecs[i].exp_id, 2'b00});
      @(posedge clk);
      #1;
    end

    // Bypass streaming: one item per cycle.
    do_reset(1'b0);
    run_phase("bypass", 3000, 100, 0, -1);
    check_output("bypass_rate", in_count, 3000);

    // Redundant mode, clean channel: one item per three cycles, no faults.
    do_reset(1'b1);
    run_phase("clean", 3000, 100, 0, -1);
    check_output("clean_rate", (in_count >= 998 && in_count <= 1002), 1'b1);
    check_output("clean_no_fault", fault_count, 0);

    do_reset(1'b1);
    run_phase("data_xor", 3000, 70, 1, -1);
    check_output("data_xor_faults", (fault_count > 0 && inj_count > 0), 1'b1);

    do_reset(1'b1);
    run_phase("ready_flip", 3000, 70, 3, -1);
    check_output("ready_flip_items", (in_count > 0 && inj_count > 0), 1'b1);

    do_reset(1'b1);
    run_phase("id_xor", 3000, 70, 2, -1);
    check_output("id_xor_items", (in_count > 0 && inj_count > 0), 1'b1);

    do_reset(1'b1);
    run_phase("stall", 200, 100, 0, 60);

    // Stale copy while idle must be absorbed by the lock; lock then times out.
    do_reset(1'b1);
    clear_stats();
    mon_en   = 1'b1;
    up_data  = 8'h5A;
    up_valid = 1'b1;
    @(posedge clk);
    #1 up_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk);
      #1 seen = !red_valid_s;
    end
    check_output("stale_start_idle", seen, 1'b1);
    check_output("lock_after_vote", lock, 1'b1);
    inj_valid = 1'b1;
    @(posedge clk);
    #1 inj_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("stale_single_out", out_count, 1);
    check_output("stale_no_fault", fault_count, 0);
    repeat (8) @(posedge clk);
    #1;
    check_output("lock_timeout", lock, 1'b0);
    check_output("stale_drained", exp_q.size(), 0);
    mon_en = 1'b0;

    // Reset in the middle of an item discards it.
    do_reset(1'b1);
    up_data  = 8'h77;
    up_valid = 1'b1;
    @(posedge clk);
    #1 up_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    clear_stats();
    mon_en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    mon_en = 1'b0;
    check_output("midrst_no_output", out_count, 0);
    check_output("midrst_idle", {red_valid_s, dn_valid, lock}, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
